truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//  Sequencer that sweeps every input combination through an external N-input
//  combinational block (default: 5-input SOP f = V'W'Z' + WY'Z + VXZ) and
//  captures each output into a truth-table register.
//  Counts ones, compares against a parameterised golden mask and reports
//  pass/fail with the first failing index.
//  Replaces hand-written vector lists in benches and is reusable as a
//  self-test controller on any 5-input gate-level circuit.
// PARAMETERS
//  N_IN      5             number of DUT inputs; table depth = 2**N_IN
//  SETTLE    1             wait cycles after driving a vector before sampling (0..15)
//  EXPECTED  32'hA2A02255  golden truth table; bit i = f(index i); minterms 0,2,4,6,9,13,21,23,25,29,31
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous, active-high reset
//  start       in   1          one-cycle request; accepted in IDLE or DONE only
//  vec_out     out  N_IN       drive to DUT; vec_out[N_IN-1] = V (MSB) ... vec_out[0] = Z
//  dut_out     in   1          DUT output (out1)
//  busy        out  1          high while in RUN
//  done        out  1          high while in DONE (level, held until next start or rst)
//  table_out   out  2**N_IN    captured truth table; bit i = dut_out sampled for vec i
//  ones_count  out  N_IN+1     number of 1s in table_out (0..32)
//  pass        out  1          valid when done; 1 iff table_out == EXPECTED
//  fail_count  out  N_IN+1     number of mismatching indices
//  first_fail  out  N_IN       lowest mismatching index; 0 when fail_count == 0
// BEHAVIOUR
//  Reset: state = IDLE; vec_out, busy, done, table_out, ones_count, pass,
//  fail_count and first_fail all = 0. rst overrides start.
//  States: IDLE -start-> RUN; RUN -last sample-> DONE; DONE -start-> RUN. No other transitions.
//  Start acceptance (cycle 0, start = 1 in IDLE or DONE):
//   - next cycle: RUN, vec_out = 0, cnt = SETTLE, busy = 1, done = 0
//   - table_out, counts, pass and first_fail cleared to 0
//  RUN, each cycle:
//   - cnt != 0: cnt decrements; vec_out is held
//   - cnt == 0: capture table_out[vec_out] <= dut_out and update counters
//  Counter update on capture:
//   - ones_count += dut_out
//   - on dut_out != EXPECTED[vec_out]: fail_count += 1; first_fail <= vec_out if it is the first mismatch
//   - then: if vec_out == 2**N_IN-1, go to DONE; otherwise vec_out += 1 and cnt = SETTLE
//  Timing:
//   - each vector occupies SETTLE+1 cycles
//   - done rises (2**N_IN)*(SETTLE+1)+1 cycles after the start cycle (65 for defaults)
//  DONE:
//   - busy = 0, done = 1, pass = (fail_count == 0)
//   - vec_out holds 2**N_IN-1; results are stable until the next start
//  start while in RUN: ignored. The sweep is not restarted and no error is flagged.
//  rst mid-sweep: immediate return to IDLE with all outputs at reset values;
//  partial results are discarded.
//  Widths: vec_out index wraps are never used (the sweep terminates at max);
//  counters are N_IN+1 bits so a full-ones table (32) does not overflow.
//  pass is 0 outside DONE.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//  localparam DEPTH = 2**N_IN, and default EXPECTED constant for the SOP5 circuit.
//  One sub-module: tt_settle_timer (load SETTLE, count down, flag zero).
//  FSM, index counter and capture/compare logic live in the top.
//  The scanner does not instantiate the DUT; the bench or parent wires
//  vec_out and dut_out to it.
// TESTING
//  1 Default SOP5 DUT, SETTLE=1, start pulse.
//    -> done at cycle 65; table_out=32'hA2A02255; ones_count=11; pass=1; fail_count=0; first_fail=0
//  2 DUT replaced by stuck-at-0 model.
//    -> table_out=0; ones_count=0; pass=0; fail_count=11; first_fail=0
//  3 DUT with term VXZ removed (minterms 21,23,31 lost).
//    -> table_out=32'h22002255; pass=0; fail_count=3; first_fail=21
//  4 SETTLE=0, default DUT.
//    -> done at cycle 33; same results as scenario 1. Also check vec_out steps every cycle 0..31.
//  5 start re-pulsed at cycle 10 of RUN.
//    -> ignored; done still at cycle 65.
//    start in DONE -> new sweep; done drops the next cycle and results clear.
//  6 rst asserted at cycle 20 of RUN.
//    -> next cycle all outputs 0, state IDLE; a subsequent start completes a normal full sweep.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared types and constants for the truth-table scanner
// Provides the scanner state encoding, the default table depth and the golden
// truth table of the default 5-input SOP circuit f = V'W'Z' + WY'Z + VXZ.
package truth_table_scanner_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int N_IN_DEFAULT = 5;
    localparam int DEPTH = 2**N_IN_DEFAULT;
    // Minterms 0,2,4,6,9,13,21,23,25,29,31
    localparam logic [DEPTH-1:0] SOP5_EXPECTED = 32'hA2A02255;
endpackage

// File: rtl/truth_table_scanner_timer.sv
// tt_settle_timer: settle-delay down-counter for the truth-table scanner
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset (counter cleared)
//   i_load  reload the counter with SETTLE
//   o_zero  high when the counter has reached zero (sample may be taken)
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_zero
);
    logic [3:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= 4'(SETTLE);
        else if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end
    assign o_zero = (r_cnt == 4'd0);
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps all input vectors through an external block and grades its truth table
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        one-cycle sweep request, honoured in IDLE or DONE only
//   o_vec_out      vector driven to the block under test (MSB = V ... LSB = Z)
//   i_dut_out      output of the block under test
//   o_busy         high while sweeping
//   o_done         high while results are held
//   o_table_out    captured truth table, bit i = output for vector i
//   o_ones_count   number of ones in the captured table
//   o_pass         1 in DONE iff the table matches EXPECTED
//   o_fail_count   number of mismatching indices
//   o_first_fail   lowest mismatching index (0 if none)
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int                  N_IN     = 5,
    parameter int                  SETTLE   = 1,
    parameter logic [2**N_IN-1:0]  EXPECTED = SOP5_EXPECTED
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic [N_IN-1:0]     o_vec_out,
    input  logic                i_dut_out,
    output logic                o_busy,
    output logic                o_done,
    output logic [2**N_IN-1:0]  o_table_out,
    output logic [N_IN:0]       o_ones_count,
    output logic                o_pass,
    output logic [N_IN:0]       o_fail_count,
    output logic [N_IN-1:0]     o_first_fail
);
    localparam int L_DEPTH = 2**N_IN;

    state_t              r_state;
    logic [N_IN-1:0]     r_vec;
    logic [L_DEPTH-1:0]  r_table;
    logic [N_IN:0]       r_ones;
    logic [N_IN:0]       r_fails;
    logic [N_IN-1:0]     r_first;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic                w_start_ok;
    logic                w_zero;
    logic                w_capture;
    logic                w_last;
    logic                w_mismatch;
    logic [N_IN:0]       w_fail_next;
    logic                w_load;

    assign w_start_ok  = i_start && (r_state != RUN);
    assign w_capture   = (r_state == RUN) && w_zero;
    assign w_last      = (r_vec == N_IN'(L_DEPTH - 1));
    assign w_mismatch  = (i_dut_out != EXPECTED[r_vec]);
    assign w_fail_next = r_fails + (N_IN+1)'(w_mismatch);
    // Settle count restarts on every new vector, including the first one
    assign w_load      = w_start_ok || (w_capture && !w_last);

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .o_zero (w_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_table <= '0;
            r_ones  <= '0;
            r_fails <= '0;
            r_first <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (w_start_ok) begin
            r_state <= RUN;
            r_vec   <= '0;
            r_table <= '0;
            r_ones  <= '0;
            r_fails <= '0;
            r_first <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (w_capture) begin
            r_table[r_vec] <= i_dut_out;
            r_ones         <= r_ones + (N_IN+1)'(i_dut_out);
            r_fails        <= w_fail_next;
            // Record only the first mismatch of the sweep
            if (w_mismatch && (r_fails == '0))
                r_first <= r_vec;
            if (w_last) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= (w_fail_next == '0);
            end else begin
                r_vec <= r_vec + N_IN'(1);
            end
        end
    end

    assign o_vec_out    = r_vec;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_table_out  = r_table;
    assign o_ones_count = r_ones;
    assign o_pass       = r_pass;
    assign o_fail_count = r_fails;
    assign o_first_fail = r_first;
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench for truth_table_scanner with SETTLE=1 and SETTLE=0 instances
module tb_truth_table_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] tt;
        int          ones;
        bit          pass;
        int          fails;
        int          first;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic        rst_a, start_a, dut_a, busy_a, done_a, pass_a;
    logic [4:0]  vec_a, first_a;
    logic [31:0] table_a;
    logic [5:0]  ones_a, fails_a;
    logic        rst_b, start_b, dut_b, busy_b, done_b, pass_b;
    logic [4:0]  vec_b, first_b;
    logic [31:0] table_b;
    logic [5:0]  ones_b, fails_b;

    int          mode_a = 0, mode_b = 0;
    logic [31:0] rt_a = '0, rt_b = '0;

    // Modes: 0 SOP5, 1 stuck-at-0, 2 SOP5 without VXZ, 3 arbitrary table rt
    function automatic logic ref_f(int m, logic [4:0] i, logic [31:0] rt);
        logic v, w, x, y, z, t1, t2, t3;
        {v, w, x, y, z} = i;
        t1 = !v && !w && !z;
        t2 = w && !y && z;
        t3 = v && x && z;
        return (m == 0) ? (t1 | t2 | t3) : (m == 1) ? 1'b0 : (m == 2) ? (t1 | t2) : rt[i];
    endfunction

    function automatic bit golden(int i);
        int mins[11] = '{0, 2, 4, 6, 9, 13, 21, 23, 25, 29, 31};
        foreach (mins[k]) if (mins[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t predict(int m, logic [31:0] rt, int settle);
        exp_t e;
        e.tt = '0; e.ones = 0; e.fails = 0; e.first = 0;
        for (int i = 0; i < 32; i++) begin
            logic b;
            b = ref_f(m, 5'(i), rt);
            e.tt[i] = b;
            e.ones += int'(b);
            if (b != golden(i)) begin
                if (e.fails == 0) e.first = i;
                e.fails++;
            end
        end
        e.pass = (e.fails == 0);
        e.lat = 32 * (settle + 1) + 1;
        e.start_cyc = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    assign dut_a = ref_f(mode_a, vec_a, rt_a);
    assign dut_b = ref_f(mode_b, vec_b, rt_b);

    truth_table_scanner #(.N_IN(5), .SETTLE(1)) u_a (
        .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .o_vec_out(vec_a), .i_dut_out(dut_a),
        .o_busy(busy_a), .o_done(done_a), .o_table_out(table_a), .o_ones_count(ones_a),
        .o_pass(pass_a), .o_fail_count(fails_a), .o_first_fail(first_a)
    );

    truth_table_scanner #(.N_IN(5), .SETTLE(0)) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .o_vec_out(vec_b), .i_dut_out(dut_b),
        .o_busy(busy_b), .o_done(done_b), .o_table_out(table_b), .o_ones_count(ones_b),
        .o_pass(pass_b), .o_fail_count(fails_b), .o_first_fail(first_b)
    );

    logic pd_a = 1'b0, pd_b = 1'b0;

    always @(negedge clk) begin
        if (done_a && !pd_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_table", 64'(table_a), 64'(e.tt));
                chk("a_ones", 64'(ones_a), 64'(e.ones));
                chk("a_pass", 64'(pass_a), 64'(e.pass));
                chk("a_fails", 64'(fails_a), 64'(e.fails));
                chk("a_first", 64'(first_a), 64'(e.first));
                chk("a_latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                chk("a_vec_hold", 64'(vec_a), 64'(31));
                chk("a_busy_low", 64'(busy_a), 64'(0));
            end
        end
        pd_a <= done_a;
    end

    always @(negedge clk) begin
        if (busy_b && q_b.size() != 0) begin
            chk("b_vec_step", 64'(vec_b), 64'(cyc - q_b[0].start_cyc - 1));
            chk("b_pass_low", 64'(pass_b), 64'(0));
        end
        if (done_b && !pd_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_table", 64'(table_b), 64'(e.tt));
                chk("b_ones", 64'(ones_b), 64'(e.ones));
                chk("b_pass", 64'(pass_b), 64'(e.pass));
                chk("b_fails", 64'(fails_b), 64'(e.fails));
                chk("b_first", 64'(first_b), 64'(e.first));
                chk("b_latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
        end
        pd_b <= done_b;
    end

    task automatic go_a(int m, logic [31:0] rt);
        exp_t e;
        mode_a = m; rt_a = rt;
        e = predict(m, rt, 1);
        e.start_cyc = cyc;
        q_a.push_back(e);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic go_b(int m, logic [31:0] rt);
        exp_t e;
        mode_b = m; rt_b = rt;
        e = predict(m, rt, 0);
        e.start_cyc = cyc;
        q_b.push_back(e);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic drain(int which);
        for (int i = 0; i < 200; i++) begin
            if ((which == 0 ? q_a.size() : q_b.size()) == 0) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL timeout waiting for done on scanner %0d", which);
        if (which == 0) q_a.delete(); else q_b.delete();
    endtask

    task automatic chk_cleared_a(string tag);
        chk({tag, "_vec"}, 64'(vec_a), 64'(0));
        chk({tag, "_done"}, 64'(done_a), 64'(0));
        chk({tag, "_table"}, 64'(table_a), 64'(0));
        chk({tag, "_ones"}, 64'(ones_a), 64'(0));
        chk({tag, "_pass"}, 64'(pass_a), 64'(0));
        chk({tag, "_fails"}, 64'(fails_a), 64'(0));
        chk({tag, "_first"}, 64'(first_a), 64'(0));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared_a("reset");
        chk("reset_busy", 64'(busy_a), 64'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        go_a(0, '0);
        drain(0);
        chk("s1_table_const", 64'(table_a), 64'(32'hA2A02255));
        chk("s1_ones_const", 64'(ones_a), 64'(11));

        go_a(1, '0);
        chk("done_restart_busy", 64'(busy_a), 64'(1));
        chk_cleared_a("done_restart");
        drain(0);

        go_a(2, '0);
        drain(0);
        chk("s3_table_const", 64'(table_a), 64'(32'h22002255));
        chk("s3_first_const", 64'(first_a), 64'(21));

        go_a(0, '0);
        repeat (9) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        drain(0);

        go_a(0, '0);
        repeat (19) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        void'(q_a.pop_back());
        chk_cleared_a("midrst");
        chk("midrst_busy", 64'(busy_a), 64'(0));
        go_a(0, '0);
        drain(0);

        repeat (6) begin
            go_a(int'($urandom_range(0, 3)), $urandom);
            drain(0);
        end

        go_b(0, '0);
        drain(1);
        repeat (4) begin
            go_b(int'($urandom_range(0, 3)), $urandom);
            drain(1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
